// File: rtl/sequence_player.sv
// sequence_player: replays the stored colour sequence oldest-first with fixed on/off timing.
// Optional SEQUENCE_PLAYER_ABORT_EN adds an abort input that cancels playback in ON/OFF.
module sequence_player #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       seq_len,
  input  logic [32:0][1:0] segment,
  input  logic             abort,
  output logic [1:0]       colour_out,
  output logic             colour_valid,
  output logic             busy,
  output logic             done
);
  localparam int MAXC = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [TW-1:0] ON_T = TW'(ON_CYCLES);
  localparam logic [TW-1:0] OFF_T = TW'(OFF_CYCLES);
  localparam logic [TW-1:0] T_END = TW'(1);
  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;
  state_t state, state_n;
  logic [32:1][1:0] snap, snap_n;
  logic [5:0] idx, idx_n, len, dec;
  logic [TW-1:0] timer, timer_n;
  logic [1:0] colour_n;
  logic valid_n, busy_n, done_n;
  logic unused;
  assign len = seq_len > 6'd32 ? 6'd32 : seq_len;
  assign dec = idx != 6'd0 ? idx - 6'd1 : 6'd0;
`ifdef SEQUENCE_PLAYER_ABORT_EN
  assign unused = ^segment[0];
`else
  assign unused = ^{abort, segment[0]};
`endif
  always_comb begin
    state_n = state;
    snap_n = snap;
    idx_n = idx;
    timer_n = timer;
    colour_n = colour_out;
    valid_n = colour_valid;
    busy_n = busy;
    done_n = 1'b0;
    case (state)
      IDLE: if (start) begin
        snap_n = segment[32:1];
        idx_n = len;
        busy_n = 1'b1;
        state_n = len == 6'd0 ? DONE : ON;
        done_n = len == 6'd0;
        timer_n = ON_T;
        colour_n = len == 6'd0 ? 2'd0 : segment[len];
        valid_n = len != 6'd0;
      end
      ON: if (timer == T_END) begin
        state_n = OFF;
        timer_n = OFF_T;
        colour_n = 2'd0;
        valid_n = 1'b0;
      end else timer_n = timer - T_END;
      OFF: if (timer == T_END) begin
        idx_n = dec;
        state_n = dec == 6'd0 ? DONE : ON;
        done_n = dec == 6'd0;
        timer_n = ON_T;
        colour_n = dec == 6'd0 ? 2'd0 : snap[dec];
        valid_n = dec != 6'd0;
      end else timer_n = timer - T_END;
      DONE: begin
        state_n = IDLE;
        busy_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
`ifdef SEQUENCE_PLAYER_ABORT_EN
    if (abort && (state == ON || state == OFF)) begin
      state_n = IDLE;
      colour_n = 2'd0;
      valid_n = 1'b0;
      busy_n = 1'b0;
      done_n = 1'b0;
    end
`endif
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      snap <= '0;
      idx <= '0;
      timer <= '0;
      colour_out <= 2'd0;
      colour_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      snap <= snap_n;
      idx <= idx_n;
      timer <= timer_n;
      colour_out <= colour_n;
      colour_valid <= valid_n;
      busy <= busy_n;
      done <= done_n;
    end
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: randomized playback bench with a per-cycle arithmetic reference model.
module tb_sequence_player;
`ifdef SEQUENCE_PLAYER_ABORT_EN
  localparam bit ABORT_ON = 1'b1;
`else
  localparam bit ABORT_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [5:0] seq_len = '0;
  logic [32:0][1:0] seg = '0;
  logic [1:0] colour_out;
  logic colour_valid, busy, done;
  int checks = 0;
  int errors = 0;
  int m_n;
  logic [1:0] m_col [1:32];

  sequence_player #(.ON_CYCLES(3), .OFF_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .seq_len(seq_len), .segment(seg),
    .abort(abort), .colour_out(colour_out), .colour_valid(colour_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Expected {colour, valid, busy, done} during cycle t+o, colour k lit for 3 of every 5 cycles.
  function automatic logic [4:0] model(input int o, input int ab);
    int k, ph;
    if (ABORT_ON && ab > 0 && o > ab) return 5'b0;
    if (o == 1 + 5 * m_n) return 5'b00011;
    if (o > 1 + 5 * m_n) return 5'b0;
    k = (o - 1) / 5;
    ph = (o - 1) % 5;
    return ph < 3 ? {m_col[m_n - k], 3'b110} : 5'b00010;
  endfunction

  task automatic play(input int len, input bit perturb, input bit noise, input int abort_at);
    logic [4:0] got, exp;
    m_n = len > 32 ? 32 : len;
    for (int i = 1; i <= 32; i++) m_col[i] = seg[i];
    seq_len = 6'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int o = 1; o <= 2 + 5 * m_n; o++) begin
      got = {colour_out, colour_valid, busy, done};
      exp = model(o, abort_at);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL play len=%0d o=%0d got=%b exp=%b", len, o, got, exp);
      end
      if (o < 2 + 5 * m_n) begin
        if (perturb && o == 2) for (int i = 0; i < 33; i++) seg[i] = ~seg[i];
        start = noise && o <= 5 * m_n && $urandom_range(0, 1) == 1;
        abort = (o == abort_at);
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({colour_out, colour_valid, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_init got=%b exp=00000", {colour_out, colour_valid, busy, done});
    end
    reset = 1'b1;
    seg[3] = 2'd2; seg[2] = 2'd0; seg[1] = 2'd3;
    seq_len = 6'd3;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({colour_out, colour_valid, busy, done} !== 5'b10110) begin
      errors++;
      $display("FAIL reset_pre_on got=%b exp=10110", {colour_out, colour_valid, busy, done});
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({colour_out, colour_valid, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=00000", {colour_out, colour_valid, busy, done});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({colour_out, colour_valid, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=00000", {colour_out, colour_valid, busy, done});
    end
    play(3, 1'b0, 1'b0, 0);
  endtask

  task automatic test_basic();
    seg = '0;
    seg[3] = 2'd2; seg[2] = 2'd0; seg[1] = 2'd3;
    play(3, 1'b1, 1'b1, 0);
  endtask

  task automatic test_len_edges();
    seg = '0;
    for (int i = 0; i < 33; i++) seg[i] = 2'($urandom);
    play(0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 33; i++) seg[i] = 2'd1;
    play(40, 1'b0, 1'b0, 0);
    for (int i = 0; i < 33; i++) seg[i] = 2'($urandom);
    play(32, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 33; i++) seg[i] = 2'($urandom);
    play(2, 1'b0, 1'b0, 0);
    play(5, 1'b0, 1'b0, 0);
    play(1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_abort();
    seg = '0;
    seg[3] = 2'd2; seg[2] = 2'd0; seg[1] = 2'd3;
    play(3, 1'b0, 1'b0, 7);
    play(2, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    int len, n, ab;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 33; i++) seg[i] = 2'($urandom);
      len = $urandom_range(0, 40);
      n = len > 32 ? 32 : len;
      ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 5 * n) : 0;
      play(len, 1'($urandom), ab == 0 && $urandom_range(0, 1) == 1, ab);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_edges();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
